// File: rtl/rom_download_ctrl.sv
// Sequences 16-bit HPS ioctl ROM words into byte writes across four ROM regions.
// It also holds the core in reset during the download and for a fixed time after it ends.
module rom_download_ctrl #(
    parameter logic [7:0]  DL_INDEX = 8'd0,
    parameter int          ADDR_W   = 16,
    parameter logic [26:0] R1_BASE  = 27'h8000,
    parameter logic [26:0] R2_BASE  = 27'hC000,
    parameter logic [26:0] R3_BASE  = 27'hE000,
    parameter logic [26:0] END_ADDR = 27'hE800,
    parameter int          HOLD_CYC = 1024
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [26:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    output logic              rom_we,
    output logic [3:0]        rom_sel,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              core_reset,
    output logic              dl_done
);

    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    state_t             state, state_next;
    logic [26:0]        addr_lat, addr_lat_next;
    logic [7:0]         dout_hi, dout_hi_next;
    logic               issue;
    logic [26:0]        byte_a;
    logic [7:0]         byte_d;
    logic               dec_we;
    logic [3:0]         dec_sel;
    logic [ADDR_W-1:0]  dec_off;
    logic               we_next;
    logic [3:0]         sel_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [7:0]         data_next;
    logic               wait_next;

    logic               active, active_q, armed;
    logic [CNT_W-1:0]   hold_cnt;

    assign active = ioctl_download && (ioctl_index == DL_INDEX);

    // Bytes at or beyond END_ADDR decode to no region and are silently dropped.
    function automatic logic [ADDR_W+4:0] decode(input logic [26:0] a);
        logic [3:0]        sel;
        logic [ADDR_W-1:0] off;
        if (a < R1_BASE) begin
            sel = 4'b0001;
            off = ADDR_W'(a);
        end else if (a < R2_BASE) begin
            sel = 4'b0010;
            off = ADDR_W'(a - R1_BASE);
        end else if (a < R3_BASE) begin
            sel = 4'b0100;
            off = ADDR_W'(a - R2_BASE);
        end else if (a < END_ADDR) begin
            sel = 4'b1000;
            off = ADDR_W'(a - R3_BASE);
        end else begin
            sel = 4'b0000;
            off = '0;
        end
        return {(sel != 4'b0000), sel, off};
    endfunction

    always_comb begin
        state_next    = state;
        addr_lat_next = addr_lat;
        dout_hi_next  = dout_hi;
        issue         = 1'b0;
        byte_a        = '0;
        byte_d        = '0;
        case (state)
            IDLE: begin
                if (ioctl_wr && active) begin
                    addr_lat_next = ioctl_addr;
                    dout_hi_next  = ioctl_dout[15:8];
                    state_next    = WR_LO;
                    issue         = 1'b1;
                    byte_a        = ioctl_addr;
                    byte_d        = ioctl_dout[7:0];
                end
            end
            WR_LO: begin
                state_next = WR_HI;
                issue      = 1'b1;
                byte_a     = addr_lat + 27'd1;
                byte_d     = dout_hi;
            end
            WR_HI:   state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are computed one state ahead so the registered byte strobe lines up with its state.
        {dec_we, dec_sel, dec_off} = decode(byte_a);
        we_next   = issue && dec_we;
        sel_next  = we_next ? dec_sel : 4'b0000;
        addr_next = we_next ? dec_off : '0;
        data_next = issue ? byte_d : 8'h00;
        wait_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_lat   <= '0;
            dout_hi    <= '0;
            ioctl_wait <= 1'b0;
            rom_we     <= 1'b0;
            rom_sel    <= 4'b0000;
            rom_addr   <= '0;
            rom_data   <= 8'h00;
        end else begin
            state      <= state_next;
            addr_lat   <= addr_lat_next;
            dout_hi    <= dout_hi_next;
            ioctl_wait <= wait_next;
            rom_we     <= we_next;
            rom_sel    <= sel_next;
            rom_addr   <= addr_next;
            rom_data   <= data_next;
        end
    end

    // The hold countdown only runs once a download has been seen, so the core stays in reset until the first ROM load.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            active_q   <= 1'b0;
            armed      <= 1'b0;
            hold_cnt   <= CNT_W'(HOLD_CYC);
            core_reset <= 1'b1;
            dl_done    <= 1'b0;
        end else begin
            active_q <= active;
            if (active && !active_q) begin
                armed      <= 1'b1;
                hold_cnt   <= CNT_W'(HOLD_CYC);
                core_reset <= 1'b1;
                dl_done    <= 1'b0;
            end else if (armed && !active && state == IDLE) begin
                if (hold_cnt == '0) begin
                    armed      <= 1'b0;
                    core_reset <= 1'b0;
                    dl_done    <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Randomized self-checking bench for rom_download_ctrl; byte writes are predicted from a region-table model.
module tb_rom_download_ctrl;

    localparam int HOLD = 40;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic        rom_we;
    logic [3:0]  rom_sel;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        dl_done;

    int total = 0;
    int bad   = 0;

    int region_base[5] = '{0, 'h8000, 'hC000, 'hE000, 'hE800};

    rom_download_ctrl #(.HOLD_CYC(HOLD)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_we         (rom_we),
        .rom_sel        (rom_sel),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .core_reset     (core_reset),
        .dl_done        (dl_done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_byte(input int a, output bit we, output logic [3:0] sel, output int off);
        we  = 1'b0;
        sel = 4'b0000;
        off = 0;
        for (int r = 0; r < 4; r++) begin
            if (a >= region_base[r] && a < region_base[r+1]) begin
                we  = 1'b1;
                sel = 4'(1 << r);
                off = (a - region_base[r]) & 'hFFFF;
            end
        end
    endfunction

    // One word transaction: strobe at a negedge, then check both byte cycles and the idle cycle after.
    task automatic applyStimulus(input int addr, input logic [15:0] data, input bit dl,
                                 input logic [7:0] idx, input bit drop_mid);
        bit          acc;
        bit          exp_we;
        logic [3:0]  exp_sel;
        int          exp_off;
        logic [7:0]  exp_data;
        acc            = dl && (idx == 8'd0);
        ioctl_download = dl;
        ioctl_index    = idx;
        ioctl_addr     = 27'(addr);
        ioctl_dout     = data;
        ioctl_wr       = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        if (drop_mid) ioctl_download = 1'b0;
        for (int b = 0; b < 2; b++) begin
            model_byte(addr + b, exp_we, exp_sel, exp_off);
            exp_we   = exp_we && acc;
            exp_data = (b == 0) ? data[7:0] : data[15:8];
            checkOutput("wait_busy", 32'(ioctl_wait), 32'(acc));
            checkOutput("we", 32'(rom_we), 32'(exp_we));
            if (exp_we) begin
                checkOutput("sel", 32'(rom_sel), 32'(exp_sel));
                checkOutput("addr", 32'(rom_addr), 32'(exp_off));
                checkOutput("data", 32'(rom_data), 32'(exp_data));
            end else begin
                checkOutput("sel_off", 32'(rom_sel), 32'h0);
            end
            @(negedge clk_sys);
        end
        checkOutput("wait_idle", 32'(ioctl_wait), 32'h0);
        checkOutput("we_idle", 32'(rom_we), 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          a;
        bit          dl, drop;
        logic [7:0]  idx;

        repeat (3) @(negedge clk_sys);
        checkOutput("rst_we", 32'(rom_we), 32'h0);
        checkOutput("rst_wait", 32'(ioctl_wait), 32'h0);
        checkOutput("rst_sel", 32'(rom_sel), 32'h0);
        checkOutput("rst_addr", 32'(rom_addr), 32'h0);
        checkOutput("rst_data", 32'(rom_data), 32'h0);
        checkOutput("rst_core", 32'(core_reset), 32'h1);
        checkOutput("rst_done", 32'(dl_done), 32'h0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        applyStimulus('h0000, 16'h3412, 1, 8'd0, 0);
        applyStimulus('h8000, 16'hBEEF, 1, 8'd0, 0);
        applyStimulus('hC002, 16'h5A5A, 1, 8'd0, 0);
        applyStimulus('hE7FE, 16'hC3A1, 1, 8'd0, 0);
        applyStimulus('hE800, 16'h7777, 1, 8'd0, 0);
        applyStimulus('h7FFE, 16'h0102, 1, 8'd0, 0);
        applyStimulus('h1234, 16'h9988, 1, 8'd254, 0);
        applyStimulus('h1234, 16'h9988, 0, 8'd0, 0);
        applyStimulus('h1000, 16'hAB12, 1, 8'd0, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) a = int'($urandom_range(0, 'h3FFFFFF)) & ~1;
            else                           a = int'($urandom_range(0, 'hEFFF)) & ~1;
            dl   = ($urandom_range(0, 4) != 0);
            idx  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            drop = ($urandom_range(0, 9) == 0);
            applyStimulus(a, 16'($urandom), dl, idx, drop);
        end

        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        checkOutput("dl_core", 32'(core_reset), 32'h1);
        checkOutput("dl_done_clr", 32'(dl_done), 32'h0);
        applyStimulus('h0040, 16'h6655, 1, 8'd0, 0);
        ioctl_download = 1'b0;
        for (int k = 1; k <= HOLD; k++) begin
            @(negedge clk_sys);
            checkOutput("hold_core", 32'(core_reset), 32'h1);
        end
        checkOutput("hold_done", 32'(dl_done), 32'h0);
        @(negedge clk_sys);
        checkOutput("rel_core", 32'(core_reset), 32'h0);
        checkOutput("rel_done", 32'(dl_done), 32'h1);

        ioctl_download = 1'b1;
        @(negedge clk_sys);
        checkOutput("redl_core", 32'(core_reset), 32'h1);
        checkOutput("redl_done", 32'(dl_done), 32'h0);
        ioctl_download = 1'b0;
        repeat (10) @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        checkOutput("reload_core", 32'(core_reset), 32'h1);
        ioctl_download = 1'b0;
        repeat (HOLD) @(negedge clk_sys);
        checkOutput("reload_hold", 32'(core_reset), 32'h1);
        @(negedge clk_sys);
        checkOutput("reload_rel", 32'(core_reset), 32'h0);

        ioctl_download = 1'b1;
        ioctl_addr     = 27'h10;
        ioctl_dout     = 16'h2211;
        ioctl_wr       = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        checkOutput("abort_pre_we", 32'(rom_we), 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_we", 32'(rom_we), 32'h0);
        checkOutput("abort_wait", 32'(ioctl_wait), 32'h0);
        checkOutput("abort_core", 32'(core_reset), 32'h1);
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        checkOutput("post_we", 32'(rom_we), 32'h0);
        checkOutput("post_wait", 32'(ioctl_wait), 32'h0);
        applyStimulus('hE000, 16'h4433, 1, 8'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
